bounce_glyph_sprite: RTL and testbench

Parametrised VGA sprite for the pixel-generation path. It draws a host-loadable W×H monochrome bitmap at a position register and, when enabled, moves that sprite on every frame tick with edge bounce. It produces a registered per-pixel on flag and colour for the RGB multiplexer, plus its current position and an edge-hit pulse for game logic. It sits beside the other logo and sprite generators, fed by the VGA sync block's `pix_x`, `pix_y`, `video_on` and `refr_tick`.

---
 rtl/bounce_glyph_sprite_if.sv | 18 +
 rtl/bounce_glyph_sprite.sv | 132 +++++++++++++
 tb/tb_bounce_glyph_sprite.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bounce_glyph_sprite_if.sv
// Bitmap load bus for bounce_glyph_sprite.
//   bm_we   : row write strobe
//   bm_addr : row to write (log2(H) bits)
//   bm_data : row pixels, bit W-1 is the leftmost pixel
// master drives the bus (host side), slave receives it (sprite side).
interface bounce_glyph_sprite_if #(
  parameter int unsigned W = 32,
  parameter int unsigned H = 16
);
  localparam int unsigned AW = $clog2(H);

  logic          bm_we;
  logic [AW-1:0] bm_addr;
  logic [W-1:0]  bm_data;

  modport master (output bm_we, output bm_addr, output bm_data);
  modport slave  (input  bm_we, input  bm_addr, input  bm_data);
endinterface

// File: rtl/bounce_glyph_sprite.sv
// Bouncing monochrome sprite for the VGA pixel path.
// Draws a host-loadable W x H bitmap at (x_reg, y_reg), moves it on each
// frame tick with edge bounce, and emits a registered pixel-on flag/colour.
//   clk, reset         : pixel clock, synchronous active-high reset
//   video_on           : visible-area flag
//   refr_tick          : one-cycle frame tick
//   pix_x, pix_y       : current pixel coordinates
//   move_en            : 1 = bounce motion, 0 = hold position
//   bm                 : bitmap row write bus (slave)
//   sprite_on/_rgb     : registered pixel-on and colour (1 cycle latency)
//   pos_x, pos_y       : current top-left corner
//   edge_hit           : one-cycle pulse when either axis bounces
module bounce_glyph_sprite #(
  parameter int unsigned W     = 32,
  parameter int unsigned H     = 16,
  parameter int unsigned X0    = 300,
  parameter int unsigned Y0    = 10,
  parameter int unsigned SCR_W = 640,
  parameter int unsigned SCR_H = 480,
  parameter int unsigned VX    = 1,
  parameter int unsigned VY    = 1,
  parameter logic [2:0]  RGB   = 3'b101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  video_on,
  input  logic                  refr_tick,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic                  move_en,
  bounce_glyph_sprite_if.slave  bm,
  output logic                  sprite_on,
  output logic [2:0]            sprite_rgb,
  output logic [9:0]            pos_x,
  output logic [9:0]            pos_y,
  output logic                  edge_hit
);
  localparam int unsigned CW = $clog2(W);
  localparam int unsigned AW = $clog2(H);
  localparam logic [10:0] XLIM = 11'(SCR_W - W);
  localparam logic [10:0] YLIM = 11'(SCR_H - H);

  logic [W-1:0] bitmap [H];
  logic [9:0]   x_reg, y_reg;
  logic         dir_x, dir_y;

  logic [10:0]  x_sum, y_sum;
  logic [9:0]   x_nxt, y_nxt;
  logic         dir_x_nxt, dir_y_nxt, hit_x, hit_y;

  logic         in_box, pix_bit, on_c;
  logic [CW-1:0] col;
  logic [AW-1:0] row;

  assign pos_x = x_reg;
  assign pos_y = y_reg;

  // Next position per axis; 11-bit sums so the upper-limit compare cannot wrap.
  always_comb begin
    x_sum     = {1'b0, x_reg} + 11'(VX);
    y_sum     = {1'b0, y_reg} + 11'(VY);
    x_nxt     = x_reg;
    y_nxt     = y_reg;
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    hit_x     = 1'b0;
    hit_y     = 1'b0;

    if (dir_x) begin
      if (x_sum > XLIM) begin
        x_nxt = XLIM[9:0]; dir_x_nxt = 1'b0; hit_x = 1'b1;
      end else begin
        x_nxt = x_sum[9:0];
      end
    end else if ({1'b0, x_reg} < 11'(VX)) begin
      x_nxt = '0; dir_x_nxt = 1'b1; hit_x = 1'b1;
    end else begin
      x_nxt = x_reg - 10'(VX);
    end

    if (dir_y) begin
      if (y_sum > YLIM) begin
        y_nxt = YLIM[9:0]; dir_y_nxt = 1'b0; hit_y = 1'b1;
      end else begin
        y_nxt = y_sum[9:0];
      end
    end else if ({1'b0, y_reg} < 11'(VY)) begin
      y_nxt = '0; dir_y_nxt = 1'b1; hit_y = 1'b1;
    end else begin
      y_nxt = y_reg - 10'(VY);
    end
  end

  // Pixel decode: full-width box test, then low-bit offsets select the bitmap bit.
  always_comb begin
    in_box  = ({1'b0, pix_x} >= {1'b0, x_reg}) &&
              ({1'b0, pix_x} <  ({1'b0, x_reg} + 11'(W))) &&
              ({1'b0, pix_y} >= {1'b0, y_reg}) &&
              ({1'b0, pix_y} <  ({1'b0, y_reg} + 11'(H)));
    col     = CW'(pix_x - x_reg);
    row     = AW'(pix_y - y_reg);
    pix_bit = bitmap[row][CW'(W - 1) - col];
    on_c    = video_on & in_box & pix_bit;
  end

  // State and output registers; reset wins over a same-cycle bitmap write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(H); i++) bitmap[i] <= '0;
      x_reg      <= 10'(X0);
      y_reg      <= 10'(Y0);
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      sprite_on  <= 1'b0;
      sprite_rgb <= 3'b000;
      edge_hit   <= 1'b0;
    end else begin
      if (bm.bm_we) bitmap[bm.bm_addr] <= bm.bm_data;
      if (refr_tick && move_en) begin
        x_reg    <= x_nxt;
        y_reg    <= y_nxt;
        dir_x    <= dir_x_nxt;
        dir_y    <= dir_y_nxt;
        edge_hit <= hit_x | hit_y;
      end else begin
        edge_hit <= 1'b0;
      end
      sprite_on  <= on_c;
      sprite_rgb <= on_c ? RGB : 3'b000;
    end
  end
endmodule

// File: tb/tb_bounce_glyph_sprite.sv
// Randomized self-checking bench for bounce_glyph_sprite: two instances
// (slow VX=VY=1 and fast VX=3/VY=15) checked every cycle against a model.
module tb_bounce_glyph_sprite;
  localparam int W = 32, H = 16, X0 = 300, Y0 = 10, SCR_W = 640, SCR_H = 480;

  logic        clk = 1'b0;
  logic        reset, video_on, refr_tick, move_en;
  logic [9:0]  pix_x, pix_y;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] data;

  logic        on_o  [2];
  logic [2:0]  rgb_o [2];
  logic [9:0]  px_o  [2];
  logic [9:0]  py_o  [2];
  logic        hit_o [2];

  // reference model state
  int          mx [2];
  int          my [2];
  bit          mdx [2];
  bit          mdy [2];
  logic [31:0] mbm [16];
  int          hits_seen [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bounce_glyph_sprite_if #(.W(W), .H(H)) bm0 ();
  bounce_glyph_sprite_if #(.W(W), .H(H)) bm1 ();
  assign bm0.bm_we = we;  assign bm0.bm_addr = addr;  assign bm0.bm_data = data;
  assign bm1.bm_we = we;  assign bm1.bm_addr = addr;  assign bm1.bm_data = data;

  bounce_glyph_sprite #(.VX(1), .VY(1)) dut0 (
    .clk(clk), .reset(reset), .video_on(video_on), .refr_tick(refr_tick),
    .pix_x(pix_x), .pix_y(pix_y), .move_en(move_en), .bm(bm0),
    .sprite_on(on_o[0]), .sprite_rgb(rgb_o[0]), .pos_x(px_o[0]),
    .pos_y(py_o[0]), .edge_hit(hit_o[0]));

  bounce_glyph_sprite #(.VX(3), .VY(15)) dut1 (
    .clk(clk), .reset(reset), .video_on(video_on), .refr_tick(refr_tick),
    .pix_x(pix_x), .pix_y(pix_y), .move_en(move_en), .bm(bm1),
    .sprite_on(on_o[1]), .sprite_rgb(rgb_o[1]), .pos_x(px_o[1]),
    .pos_y(py_o[1]), .edge_hit(hit_o[1]));

  function automatic int vx_of(input int i); return (i == 0) ? 1 : 3;  endfunction
  function automatic int vy_of(input int i); return (i == 0) ? 1 : 15; endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic move_axis(input int p, input bit d, input int v, input int lim,
                           output int np, output bit nd, output bit h);
    h = 0; nd = d;
    if (d) begin
      if (p + v > lim) begin np = lim; nd = 0; h = 1; end
      else np = p + v;
    end else begin
      if (p < v) begin np = 0; nd = 1; h = 1; end
      else np = p - v;
    end
  endtask

  // One clock: predict, advance, compare every output of both instances.
  task automatic step();
    bit exp_on [2];
    bit exp_hit [2];
    int nx, ny; bit ndx, ndy, hx, hy;
    for (int i = 0; i < 2; i++) begin
      exp_on[i] = 0; exp_hit[i] = 0;
      if (!reset) begin
        int px = int'(pix_x), py = int'(pix_y);
        if (video_on && px >= mx[i] && px < mx[i] + W && py >= my[i] && py < my[i] + H)
          exp_on[i] = mbm[py - my[i]][W - 1 - (px - mx[i])];
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mx[i] = X0; my[i] = Y0; mdx[i] = 1; mdy[i] = 1;
      end else if (refr_tick && move_en) begin
        move_axis(mx[i], mdx[i], vx_of(i), SCR_W - W, nx, ndx, hx);
        move_axis(my[i], mdy[i], vy_of(i), SCR_H - H, ny, ndy, hy);
        mx[i] = nx; my[i] = ny; mdx[i] = ndx; mdy[i] = ndy;
        exp_hit[i] = hx | hy;
      end
    end
    if (reset) for (int r = 0; r < H; r++) mbm[r] = '0;
    else if (we) mbm[addr] = data;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("sprite_on%0d", i),  32'(on_o[i]),  32'(exp_on[i]));
      check($sformatf("sprite_rgb%0d", i), 32'(rgb_o[i]), exp_on[i] ? 32'd5 : 32'd0);
      check($sformatf("edge_hit%0d", i),   32'(hit_o[i]), 32'(exp_hit[i]));
      check($sformatf("pos_x%0d", i),      32'(px_o[i]),  32'(mx[i]));
      check($sformatf("pos_y%0d", i),      32'(py_o[i]),  32'(my[i]));
      if (hit_o[i] === 1'b1) hits_seen[i]++;
    end
  endtask

  task automatic idle_inputs();
    reset = 0; video_on = 1; refr_tick = 0; move_en = 0; we = 0; addr = '0; data = '0;
  endtask

  // Random pixel near one of the two sprites.
  task automatic rand_pix();
    int k = int'($urandom % 2);
    int px = mx[k] - 4 + int'($urandom_range(0, W + 8));
    int py = my[k] - 3 + int'($urandom_range(0, H + 6));
    if (px < 0) px = 0;
    if (py < 0) py = 0;
    pix_x = 10'(px); pix_y = 10'(py);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin mx[i] = 0; my[i] = 0; mdx[i] = 1; mdy[i] = 1; hits_seen[i] = 0; end
    for (int r = 0; r < H; r++) mbm[r] = '0;
    idle_inputs();
    pix_x = 10'd300; pix_y = 10'd10;

    // reset, with a write attempted during reset
    reset = 1; we = 1; addr = 4'd3; data = 32'hFFFF_FFFF;
    step();
    step();
    check("rst_pos_x", 32'(px_o[0]), 32'd300);
    check("rst_pos_y", 32'(py_o[0]), 32'd10);
    idle_inputs();
    pix_x = 10'd300; pix_y = 10'd13;
    step();
    step();
    check("rst_row3_blank", 32'(on_o[0]), 32'd0);

    // all rows ones, motion disabled; ticks must not move
    for (int r = 0; r < H; r++) begin we = 1; addr = 4'(r); data = 32'hFFFF_FFFF; step(); end
    we = 0;
    for (int n = 0; n < 400; n++) begin
      rand_pix(); video_on = ($urandom % 4) != 0; refr_tick = ($urandom % 5) == 0; step();
    end
    video_on = 1; refr_tick = 0;
    pix_x = 10'd331; pix_y = 10'd25; step();
    pix_x = 10'd332; step();
    check("box_corner_on", 32'(on_o[0]), 32'd0);  // output now reflects pixel 332
    check("hold_pos_x", 32'(px_o[0]), 32'd300);

    // row 0 = 0x80000001, others blank; scan rows 10 and 11
    for (int r = 0; r < H; r++) begin we = 1; addr = 4'(r); data = (r == 0) ? 32'h8000_0001 : 32'h0; step(); end
    we = 0;
    for (int y = 10; y <= 11; y++)
      for (int x = 296; x <= 336; x++) begin pix_x = 10'(x); pix_y = 10'(y); step(); end

    // write during render: old data at that cycle, new data next cycle
    pix_x = 10'd305; pix_y = 10'd13;
    we = 1; addr = 4'd3; data = 32'hFFFF_FFFF; step();
    check("wr_old_data", 32'(on_o[0]), 32'd0);
    we = 0; step();
    check("wr_new_data", 32'(on_o[0]), 32'd1);

    // five ticks with motion from reset
    reset = 1; step(); reset = 0;
    move_en = 1;
    for (int t = 0; t < 5; t++) begin refr_tick = 1; step(); refr_tick = 0; step(); end
    check("five_ticks_x", 32'(px_o[0]), 32'd305);
    check("five_ticks_y", 32'(py_o[0]), 32'd15);
    check("five_ticks_nohit", 32'(hits_seen[0]), 32'd0);

    // long random run with bounces, writes and rare mid-frame resets
    for (int n = 0; n < 8000; n++) begin
      rand_pix();
      reset     = ($urandom % 2500) == 0;
      video_on  = ($urandom % 8) != 0;
      refr_tick = ($urandom % 3) == 0;
      move_en   = ($urandom % 16) != 0;
      we        = ($urandom % 6) == 0;
      addr      = 4'($urandom);
      data      = $urandom;
      step();
    end

    // mid-motion reset
    idle_inputs(); move_en = 1; refr_tick = 1; reset = 1; step();
    check("midrst_pos_x", 32'(px_o[1]), 32'd300);
    check("midrst_hit", 32'(hit_o[1]), 32'd0);
    check("fast_bounced", 32'(hits_seen[1] > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
